// File: rtl/rtoc_dispatcher.sv
// RTOC dispatcher: host command fan-out to 4 RTOC cores, run/flush sequencing and error reporting.
// Optional RTOC_BACKPRESSURE_EN: cmd_ready also gated by core_full of the addressed channel.
module rtoc_dispatcher #(
  parameter int FLUSH_CYCLES = 4,
  parameter int DROP_CNT_W   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_chan,
  input  logic [127:0]          i_cmd_data,
  input  logic                  i_ctrl_start,
  input  logic                  i_ctrl_stop,
  input  logic                  i_ctrl_flush,
  output logic [3:0]            o_core_write,
  output logic [127:0]          o_core_din,
  output logic [3:0]            o_core_auto_start,
  output logic [3:0]            o_core_flush,
  input  logic [3:0]            i_core_full,
  input  logic [3:0]            i_core_ts_err,
  input  logic [3:0]            i_core_ovf_err,
  output logic                  o_err_valid,
  input  logic                  i_err_ack,
  output logic [1:0]            o_err_chan,
  output logic                  o_err_type,
  output logic [1:0]            o_state,
  output logic [DROP_CNT_W-1:0] o_err_drop_count
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;
  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

  state_t                r_state, w_state_nxt;
  logic [FC_W-1:0]       r_flush_cnt;
  logic [3:0]            r_core_write, r_core_auto_start, r_core_flush;
  logic [127:0]          r_core_din;
  logic [3:0]            r_ts_pend, r_ovf_pend;
  logic                  r_err_valid, r_err_type;
  logic [1:0]            r_err_chan, r_rr_ptr;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_enter_flush, w_active, w_accept, w_ack;
  logic [3:0]            w_ts_hit, w_ovf_hit, w_ts_clr, w_ovf_clr, w_ts_drop, w_ovf_drop;
  logic [3:0]            w_ts_pend_nxt, w_ovf_pend_nxt;
  logic [DROP_CNT_W+3:0] w_drop_sum;
  logic                  w_gnt_found, w_gnt_type, w_gnt_other;
  logic [1:0]            w_gnt_chan, w_idx;

  // Control priority: flush > stop > start; all pulses ignored in FLUSH.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_ctrl_flush) w_state_nxt = S_FLUSH;
               else if (i_ctrl_start) w_state_nxt = S_RUN;
      S_RUN:   if (i_ctrl_flush) w_state_nxt = S_FLUSH;
               else if (i_ctrl_stop) w_state_nxt = S_IDLE;
      S_FLUSH: if (r_flush_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_flush = (r_state != S_FLUSH) && (w_state_nxt == S_FLUSH);
  assign w_active      = (r_state != S_FLUSH);

`ifdef RTOC_BACKPRESSURE_EN
  assign o_cmd_ready = !i_reset && w_active && !i_core_full[i_cmd_chan];
`else
  assign o_cmd_ready = !i_reset && w_active;
`endif
  assign w_accept = i_cmd_valid && o_cmd_ready;

  // A new error pulse in the cycle its bit is acked keeps the bit set and is not a drop.
  assign w_ack          = r_err_valid && i_err_ack;
  assign w_ts_hit       = w_active ? i_core_ts_err  : 4'b0;
  assign w_ovf_hit      = w_active ? i_core_ovf_err : 4'b0;
  assign w_ts_clr       = (w_ack &&  r_err_type) ? (4'b0001 << r_err_chan) : 4'b0;
  assign w_ovf_clr      = (w_ack && !r_err_type) ? (4'b0001 << r_err_chan) : 4'b0;
  assign w_ts_drop      = w_ts_hit  & r_ts_pend  & ~w_ts_clr;
  assign w_ovf_drop     = w_ovf_hit & r_ovf_pend & ~w_ovf_clr;
  assign w_ts_pend_nxt  = (r_ts_pend  & ~w_ts_clr)  | w_ts_hit;
  assign w_ovf_pend_nxt = (r_ovf_pend & ~w_ovf_clr) | w_ovf_hit;
  assign w_drop_sum     = {4'b0, r_drop_cnt} + (DROP_CNT_W+4)'($countones({w_ts_drop, w_ovf_drop}));

  // Round-robin search from the channel after the pointer; ts beats ovf within a channel.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_chan  = 2'd0;
    w_gnt_type  = 1'b0;
    w_gnt_other = 1'b0;
    w_idx       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_gnt_found && (r_ts_pend[w_idx] || r_ovf_pend[w_idx])) begin
        w_gnt_found = 1'b1;
        w_gnt_chan  = w_idx;
        w_gnt_type  = r_ts_pend[w_idx];
        w_gnt_other = r_ts_pend[w_idx] && r_ovf_pend[w_idx];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state           <= S_IDLE;
      r_flush_cnt       <= '0;
      r_core_write      <= 4'b0;
      r_core_din        <= '0;
      r_core_auto_start <= 4'b0;
      r_core_flush      <= 4'hF;
      r_ts_pend         <= 4'b0;
      r_ovf_pend        <= 4'b0;
      r_err_valid       <= 1'b0;
      r_err_chan        <= 2'd0;
      r_err_type        <= 1'b0;
      r_rr_ptr          <= 2'd0;
      r_drop_cnt        <= '0;
    end else begin
      r_state           <= w_state_nxt;
      if (w_enter_flush)
        r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
      else if (r_state == S_FLUSH && r_flush_cnt != '0)
        r_flush_cnt <= r_flush_cnt - 1'b1;
      r_core_flush      <= (w_state_nxt == S_FLUSH) ? 4'hF : 4'h0;
      r_core_auto_start <= (w_state_nxt == S_RUN)   ? 4'hF : 4'h0;
      r_core_write      <= w_accept ? (4'b0001 << i_cmd_chan) : 4'b0;
      if (w_accept)
        r_core_din <= i_cmd_data;
      if (w_enter_flush) begin
        r_ts_pend  <= 4'b0;
        r_ovf_pend <= 4'b0;
      end else begin
        r_ts_pend  <= w_ts_pend_nxt;
        r_ovf_pend <= w_ovf_pend_nxt;
      end
      if (w_drop_sum[DROP_CNT_W+3:DROP_CNT_W] != 4'b0)
        r_drop_cnt <= '1;
      else
        r_drop_cnt <= w_drop_sum[DROP_CNT_W-1:0];
      // Pointer only moves once a channel has nothing left to report.
      if (w_enter_flush || w_ack) begin
        r_err_valid <= 1'b0;
      end else if (!r_err_valid && w_active && w_gnt_found) begin
        r_err_valid <= 1'b1;
        r_err_chan  <= w_gnt_chan;
        r_err_type  <= w_gnt_type;
        if (!w_gnt_other)
          r_rr_ptr <= w_gnt_chan;
      end
    end
  end

  assign o_core_write      = r_core_write;
  assign o_core_din        = r_core_din;
  assign o_core_auto_start = r_core_auto_start;
  assign o_core_flush      = r_core_flush;
  assign o_err_valid       = r_err_valid;
  assign o_err_chan        = r_err_chan;
  assign o_err_type        = r_err_type;
  assign o_state           = r_state;
  assign o_err_drop_count  = r_drop_cnt;

endmodule
